// File: rtl/spi_feeder_pkg.sv
// Shared types and constants for the SPI byte feeder and its FIFO.
package spi_feeder_pkg;

  // Feeder sequencing states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } feeder_state_e;

  // One buffered entry is {last, data}.
  localparam int ENTRY_W = 9;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO with registered full/empty flags.
module sync_fifo
  import spi_feeder_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             do_wr, do_rd;

  // A write while full is dropped even if a pop happens in the same cycle.
  assign do_wr   = wr_en & ~full_q;
  assign do_rd   = rd_en & ~empty_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    if (do_wr && !do_rd) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_wr && do_rd) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointers, occupancy and flags; flags reflect the occupancy after this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage array; stale contents are harmless because reset clears the pointers.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/spi_byte_feeder.sv
// Buffers framed command bytes and feeds them one at a time to an SPI transmitter.
module spi_byte_feeder
  import spi_feeder_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int GAP_CYC = 8,
  parameter int TMO_CYC = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] wr_data,
  input  logic       wr_last,
  input  logic       wr_en,
  output logic       full,
  output logic [7:0] tx_data,
  output logic       tx_data_ready,
  output logic       tx_en,
  input  logic       tx_done,
  output logic       frame_done,
  output logic       busy,
  output logic       overflow,
  output logic       timeout
);

  localparam int TMO_W = $clog2(TMO_CYC);
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  feeder_state_e      state_q, state_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               last_q, last_d;
  logic               tx_en_q, tx_en_d;
  logic               ready_q, ready_d;
  logic               frame_done_q, frame_done_d;
  logic               overflow_q, overflow_d;
  logic               timeout_q, timeout_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [GAP_W-1:0]   gap_q, gap_d;

  logic [ENTRY_W-1:0] fifo_wr_data, fifo_rd_data;
  logic               fifo_rd_en, fifo_full, fifo_empty;

  assign fifo_wr_data = {wr_last, wr_data};

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (fifo_wr_data),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign full          = fifo_full;
  assign tx_data       = tx_data_q;
  assign tx_data_ready = ready_q;
  assign tx_en         = tx_en_q;
  assign frame_done    = frame_done_q;
  assign overflow      = overflow_q;
  assign timeout       = timeout_q;
  assign busy          = (state_q != IDLE) | ~fifo_empty;

  // Next-state logic: pop, offer, wait for completion or timeout, then gap.
  always_comb begin
    state_d      = state_q;
    tx_data_d    = tx_data_q;
    last_d       = last_q;
    tx_en_d      = tx_en_q;
    ready_d      = 1'b0;
    frame_done_d = 1'b0;
    timeout_d    = timeout_q;
    tmo_d        = tmo_q;
    gap_d        = gap_q;
    fifo_rd_en   = 1'b0;
    overflow_d   = overflow_q | (wr_en & fifo_full);

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          tx_data_d  = fifo_rd_data[7:0];
          last_d     = fifo_rd_data[8];
          tx_en_d    = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        ready_d = 1'b1;
        tmo_d   = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        tx_en_d = 1'b1;
        tmo_d   = tmo_q + TMO_W'(1);
        if (tx_done) begin
          if (last_q) begin
            frame_done_d = 1'b1;
            tx_en_d      = 1'b0;
            gap_d        = '0;
            state_d      = GAP;
          end else if (fifo_empty) begin
            state_d = IDLE;
          end else begin
            fifo_rd_en = 1'b1;
            tx_data_d  = fifo_rd_data[7:0];
            last_d     = fifo_rd_data[8];
            state_d    = LOAD;
          end
        end else if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
          timeout_d = 1'b1;
          tx_en_d   = 1'b0;
          gap_d     = '0;
          state_d   = GAP;
        end
      end
      GAP: begin
        tx_en_d = 1'b0;
        if (gap_q == GAP_W'(GAP_CYC - 1)) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, output and sticky-flag registers; reset discards everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tx_data_q    <= 8'h00;
      last_q       <= 1'b0;
      tx_en_q      <= 1'b0;
      ready_q      <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      timeout_q    <= 1'b0;
      tmo_q        <= '0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      last_q       <= last_d;
      tx_en_q      <= tx_en_d;
      ready_q      <= ready_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      timeout_q    <= timeout_d;
      tmo_q        <= tmo_d;
      gap_q        <= gap_d;
    end
  end

endmodule

// File: tb/tb_spi_byte_feeder.sv
// Scoreboard bench for spi_byte_feeder with a simple model transmitter.
module tb_spi_byte_feeder;

   localparam int GAP_CYC = 8;
   localparam int TMO_CYC = 255;
   localparam int DEPTH   = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] wr_data = 8'h00;
   logic       wr_last = 1'b0;
   logic       wr_en = 1'b0;
   logic       tx_done = 1'b0;
   logic       full, tx_data_ready, tx_en, frame_done, busy, overflow, timeout;
   logic [7:0] tx_data;

   int         checks = 0;
   int         errors = 0;
   int         cycleCnt = 0;
   int         readyCnt = 0;
   int         frameDoneCnt = 0;
   int         lastReadyCycle = 0;
   int         lastWriteCycle = 0;
   int         readyCycles[$];
   logic [8:0] sbQueue[$];
   logic [8:0] monExp;
   logic       pendingLast = 1'b0;

   bit         txAuto = 1'b0;
   int         txDelay = 4;
   int         autoCountdown = 0;
   int         manualReqCnt = 0;
   int         manualAckCnt = 0;

   spi_byte_feeder #(
      .DEPTH   (DEPTH),
      .GAP_CYC (GAP_CYC),
      .TMO_CYC (TMO_CYC)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .wr_data       (wr_data),
      .wr_last       (wr_last),
      .wr_en         (wr_en),
      .full          (full),
      .tx_data       (tx_data),
      .tx_data_ready (tx_data_ready),
      .tx_en         (tx_en),
      .tx_done       (tx_done),
      .frame_done    (frame_done),
      .busy          (busy),
      .overflow      (overflow),
      .timeout       (timeout)
   );

   // Free-running clock and cycle counter used for latency measurements.
   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt++;

   // Compare one observed value with its hand-computed expectation.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
      end
   endtask

   // Present one byte on the write port for exactly one clock edge.
   task automatic applyStimulus(input logic [7:0] data, input logic last);
      @(posedge clk);
      #1;
      wr_data = data;
      wr_last = last;
      wr_en   = 1'b1;
      @(posedge clk);
      #1;
      wr_en   = 1'b0;
      wr_last = 1'b0;
      lastWriteCycle = cycleCnt;
   endtask

   task automatic sampleNext();
      @(negedge clk);
      #1;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) sampleNext();
   endtask

   task automatic waitReadyCount(input int target, input int bound, input string name);
      int n = 0;
      while (readyCnt < target && n < bound) begin
         sampleNext();
         n++;
      end
      if (readyCnt < target) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: ready count %0d, required %0d within %0d cycles", name, readyCnt, target, bound);
      end
   endtask

   task automatic waitFrameDone(input int target, input int bound, input string name);
      int n = 0;
      while (frameDoneCnt < target && n < bound) begin
         sampleNext();
         n++;
      end
      if (frameDoneCnt < target) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: frame_done count %0d, required %0d within %0d cycles", name, frameDoneCnt, target, bound);
      end
   endtask

   task automatic requestDone();
      @(negedge clk);
      manualReqCnt++;
   endtask

   // Model transmitter: answers ready after txDelay clocks when enabled, or on request.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         tx_done = 1'b0;
         if (manualReqCnt != manualAckCnt) begin
            manualAckCnt++;
            tx_done = 1'b1;
         end else if (autoCountdown == 1) begin
            tx_done = 1'b1;
            autoCountdown = 0;
         end else if (autoCountdown > 1) begin
            autoCountdown--;
         end
         if (txAuto && tx_data_ready === 1'b1 && !rst) autoCountdown = txDelay;
      end
   end

   // Monitor: pops the expected byte on every offer and checks frame ends.
   always @(negedge clk) begin
      if (!rst) begin
         if (tx_data_ready === 1'b1) begin
            readyCnt++;
            lastReadyCycle = cycleCnt;
            readyCycles.push_back(cycleCnt);
            if (sbQueue.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_ready: got tx_data 0x%0h, required no offer", tx_data);
            end else begin
               monExp = sbQueue.pop_front();
               checkOutput("tx_data", 32'(tx_data), 32'(monExp[7:0]));
               pendingLast = monExp[8];
            end
         end
         if (frame_done === 1'b1) begin
            frameDoneCnt++;
            checkOutput("frame_done_on_last", 32'(pendingLast), 32'(1));
         end
      end
   end

   // Hard stop in case the run wedges somewhere unforeseen.
   initial begin
      #600000;
      $display("[TB] FAIL watchdog: time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence.
   initial begin
      int r0, f0, idx0, lows, n, enLow, tc;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_tx_data", 32'(tx_data), 32'(0));
      checkOutput("rst_ready", 32'(tx_data_ready), 32'(0));
      checkOutput("rst_tx_en", 32'(tx_en), 32'(0));
      checkOutput("rst_frame_done", 32'(frame_done), 32'(0));
      checkOutput("rst_full", 32'(full), 32'(0));
      checkOutput("rst_busy", 32'(busy), 32'(0));
      checkOutput("rst_overflow", 32'(overflow), 32'(0));
      checkOutput("rst_timeout", 32'(timeout), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      waitCycles(2);

      // Single last-tagged byte: latency, frame_done, gap.
      $display("[TB] single byte A5");
      txAuto = 1'b1;
      txDelay = 4;
      r0 = readyCnt;
      f0 = frameDoneCnt;
      sbQueue.push_back({1'b1, 8'hA5});
      applyStimulus(8'hA5, 1'b1);
      waitFrameDone(f0 + 1, 200, "single_frame_done");
      checkOutput("single_ready_count", 32'(readyCnt - r0), 32'(1));
      checkOutput("single_latency", 32'(lastReadyCycle - lastWriteCycle), 32'(2));
      lows = 0;
      for (int i = 0; i < GAP_CYC; i++) begin
         if (i > 0) sampleNext();
         if (tx_en === 1'b0 && busy === 1'b1) lows++;
      end
      checkOutput("single_gap_tx_en_low", 32'(lows), 32'(GAP_CYC));
      sampleNext();
      checkOutput("single_idle_busy", 32'(busy), 32'(0));

      // Three-byte frame with a slow transmitter.
      $display("[TB] frame 01 02 03");
      waitCycles(5);
      txDelay = 36;
      r0 = readyCnt;
      f0 = frameDoneCnt;
      idx0 = readyCycles.size();
      sbQueue.push_back({1'b0, 8'h01});
      sbQueue.push_back({1'b0, 8'h02});
      sbQueue.push_back({1'b1, 8'h03});
      applyStimulus(8'h01, 1'b0);
      applyStimulus(8'h02, 1'b0);
      applyStimulus(8'h03, 1'b1);
      enLow = 0;
      n = 0;
      while (frameDoneCnt < f0 + 1 && n < 600) begin
         sampleNext();
         n++;
         if (readyCnt > r0 && frame_done !== 1'b1 && tx_en !== 1'b1) enLow++;
      end
      if (frameDoneCnt < f0 + 1) begin
         checks++;
         errors++;
         $display("[TB] FAIL frame_wait: frame_done count %0d, required %0d", frameDoneCnt, f0 + 1);
      end
      checkOutput("frame_ready_count", 32'(readyCnt - r0), 32'(3));
      checkOutput("frame_tx_en_drops", 32'(enLow), 32'(0));
      if (readyCycles.size() >= idx0 + 3) begin
         checkOutput("frame_spacing_1", 32'(readyCycles[idx0 + 1] - readyCycles[idx0]), 32'(36 + 2));
         checkOutput("frame_spacing_2", 32'(readyCycles[idx0 + 2] - readyCycles[idx0 + 1]), 32'(36 + 2));
      end
      waitCycles(15);
      checkOutput("frame_done_count", 32'(frameDoneCnt - f0), 32'(1));

      // Simultaneous write and pop at occupancy 3.
      $display("[TB] write and pop together at count 3");
      txAuto = 1'b0;
      r0 = readyCnt;
      f0 = frameDoneCnt;
      for (int k = 0; k < 5; k++) sbQueue.push_back({1'b0, 8'hD0 + 8'(k)});
      for (int k = 1; k <= 13; k++) sbQueue.push_back({k == 13, 8'hE0 + 8'(k)});
      applyStimulus(8'hD0, 1'b0);
      waitReadyCount(r0 + 1, 20, "same_d0_ready");
      applyStimulus(8'hD1, 1'b0);
      applyStimulus(8'hD2, 1'b0);
      applyStimulus(8'hD3, 1'b0);
      requestDone();
      applyStimulus(8'hD4, 1'b0);
      checkOutput("same_full_after_d4", 32'(full), 32'(0));
      for (int k = 1; k <= 12; k++) applyStimulus(8'hE0 + 8'(k), 1'b0);
      checkOutput("same_full_at_15", 32'(full), 32'(0));
      applyStimulus(8'hED, 1'b1);
      checkOutput("same_full_at_16", 32'(full), 32'(1));
      checkOutput("same_overflow", 32'(overflow), 32'(0));
      requestDone();
      txDelay = 3;
      txAuto = 1'b1;
      waitFrameDone(f0 + 1, 2000, "same_frame_done");
      waitCycles(15);
      checkOutput("same_ready_count", 32'(readyCnt - r0), 32'(18));
      checkOutput("same_sb_empty", 32'(sbQueue.size()), 32'(0));

      // Withheld tx_done: timeout, gap, then the next byte.
      $display("[TB] timeout");
      txAuto = 1'b0;
      r0 = readyCnt;
      f0 = frameDoneCnt;
      sbQueue.push_back({1'b0, 8'hC1});
      sbQueue.push_back({1'b1, 8'hC2});
      applyStimulus(8'hC1, 1'b0);
      applyStimulus(8'hC2, 1'b1);
      waitReadyCount(r0 + 1, 20, "tmo_c1_ready");
      n = 0;
      while (timeout !== 1'b1 && n < 400) begin
         sampleNext();
         n++;
      end
      tc = cycleCnt;
      checkOutput("tmo_flag", 32'(timeout), 32'(1));
      checkOutput("tmo_delay", 32'(tc - lastReadyCycle), 32'(TMO_CYC));
      checkOutput("tmo_tx_en", 32'(tx_en), 32'(0));
      lows = 0;
      n = 0;
      while (tx_en !== 1'b1 && n < 50) begin
         lows++;
         n++;
         sampleNext();
      end
      checkOutput("tmo_tx_en_low_cycles", 32'(lows), 32'(GAP_CYC + 1));
      waitReadyCount(r0 + 2, 20, "tmo_c2_ready");
      checkOutput("tmo_next_offer", 32'(lastReadyCycle - tc), 32'(GAP_CYC + 2));
      requestDone();
      waitFrameDone(f0 + 1, 20, "tmo_frame_done");
      checkOutput("tmo_sticky", 32'(timeout), 32'(1));

      // Seventeen writes while the transmitter is stalled.
      $display("[TB] overflow");
      waitCycles(15);
      r0 = readyCnt;
      f0 = frameDoneCnt;
      sbQueue.push_back({1'b1, 8'hE0});
      applyStimulus(8'hE0, 1'b1);
      waitReadyCount(r0 + 1, 20, "ovf_e0_ready");
      for (int k = 1; k <= 16; k++) begin
         sbQueue.push_back({k == 16, 8'h10 + 8'(k)});
         applyStimulus(8'h10 + 8'(k), k == 16);
         if (k == 15) checkOutput("ovf_full_at_15", 32'(full), 32'(0));
      end
      checkOutput("ovf_full_at_16", 32'(full), 32'(1));
      checkOutput("ovf_clear_at_16", 32'(overflow), 32'(0));
      applyStimulus(8'h21, 1'b0);
      checkOutput("ovf_set", 32'(overflow), 32'(1));
      checkOutput("ovf_still_full", 32'(full), 32'(1));
      requestDone();
      txDelay = 3;
      txAuto = 1'b1;
      waitFrameDone(f0 + 2, 3000, "ovf_drain");
      waitCycles(20);
      checkOutput("ovf_ready_count", 32'(readyCnt - r0), 32'(17));
      checkOutput("ovf_sb_empty", 32'(sbQueue.size()), 32'(0));
      checkOutput("ovf_sticky", 32'(overflow), 32'(1));
      checkOutput("ovf_busy_end", 32'(busy), 32'(0));

      // Asynchronous reset in WAIT_DONE with five bytes queued.
      $display("[TB] reset mid byte");
      txAuto = 1'b0;
      r0 = readyCnt;
      sbQueue.push_back({1'b0, 8'hF0});
      applyStimulus(8'hF0, 1'b0);
      for (int k = 1; k <= 5; k++) applyStimulus(8'hF0 + 8'(k), k == 5);
      waitReadyCount(r0 + 1, 20, "rst_f0_ready");
      waitCycles(3);
      checkOutput("pre_rst_tx_en", 32'(tx_en), 32'(1));
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("async_tx_data", 32'(tx_data), 32'(0));
      checkOutput("async_ready", 32'(tx_data_ready), 32'(0));
      checkOutput("async_tx_en", 32'(tx_en), 32'(0));
      checkOutput("async_frame_done", 32'(frame_done), 32'(0));
      checkOutput("async_busy", 32'(busy), 32'(0));
      checkOutput("async_full", 32'(full), 32'(0));
      checkOutput("async_overflow", 32'(overflow), 32'(0));
      checkOutput("async_timeout", 32'(timeout), 32'(0));
      sbQueue.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      r0 = readyCnt;
      waitCycles(30);
      checkOutput("post_rst_no_offer", 32'(readyCnt - r0), 32'(0));
      checkOutput("post_rst_busy", 32'(busy), 32'(0));
      txAuto = 1'b1;
      txDelay = 4;
      f0 = frameDoneCnt;
      sbQueue.push_back({1'b1, 8'h77});
      applyStimulus(8'h77, 1'b1);
      waitFrameDone(f0 + 1, 100, "post_rst_frame");
      checkOutput("post_rst_ready_count", 32'(readyCnt - r0), 32'(1));
      waitCycles(15);
      checkOutput("final_sb_empty", 32'(sbQueue.size()), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
